bit_deser_capture: RTL and testbench
====================================

Name: bit_deser_capture

Overview:
- Serial-to-parallel capture stage, directly downstream of the single-bit flop cells (adff/dffe-class stages).
- Consumes the registered q bit stream under a sample strobe and assembles WIDTH-bit words, LSB first.
- Presents completed words on a valid/ready output with a one-word holding register.
- Flags dropped words (overflow) and aborted partial words.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr  in  1  asynchronous active-high reset.
- d  in  1  serial data bit, i.e. q of the upstream flop.
- en  in  1  sample strobe; d is consumed only when en=1.
- sync  in  1  start-of-word marker; qualified by en.
- out_ready  in  1  downstream accepts out_data when out_valid=1.
- ovf_clr  in  1  synchronous clear of the sticky overflow flag.
- out_valid  out  1  out_data holds an unconsumed word.
- out_data  out  WIDTH  assembled word; bit0 = first bit received.
- overflow  out  1  sticky; a completed word was dropped.
- abort_pulse  out  1  one-cycle pulse; a partial word was discarded by a new sync.
- bit_cnt  out  CNT_W  bits captured in the current word.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, shift register=0, bit_cnt=0.
  - out_valid=0, out_data=0, overflow=0, abort_pulse=0.
- FSM states IDLE and SHIFT.
- IDLE:
  - en=1 & sync=1: shreg[0]=d, bit_cnt=1, go SHIFT.
  - en=1 & sync=0: bit ignored.
  - en=0: hold.
- SHIFT, en=1 & sync=0: shreg[bit_cnt]=d, bit_cnt+1.
- SHIFT, en=1 & sync=1: partial word discarded.
  - abort_pulse=1 next cycle.
  - shreg[0]=d, bit_cnt=1, stay SHIFT.
  - A sync on the bit that would complete the word also aborts; no word is emitted.
- SHIFT, en=0: hold all state.
- Completion: the en (sync=0) carrying bit index WIDTH-1.
  - Word = {d, shreg[WIDTH-2:0]}.
  - bit_cnt returns to 0, state returns to IDLE; the next word needs a new sync.
- Output register on completion:
  - Accepted if out_valid=0, or if out_valid=1 & out_ready=1 in the same cycle (simultaneous drain and load).
  - If accepted: out_data=word, out_valid=1 next cycle. Latency is exactly 1 clk after the final-bit en.
  - Otherwise the word is dropped, out_data is unchanged, and overflow=1 next cycle.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - Without a simultaneous completion, out_valid goes to 0 next cycle; out_data holds its last value.
  - out_data is stable while out_valid=1 & out_ready=0.
- overflow:
  - Set on a drop; cleared by ovf_clr=1 on the next edge.
  - Set wins when a drop and ovf_clr occur in the same cycle.
- bit_cnt never exceeds WIDTH-1 as a visible value; no wrap beyond WIDTH.
- clr mid-word or mid-handshake: immediate return to reset values; partial word and pending output are lost.

Optional Feature:
- Macro: BIT_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits, state PARITY consumes one more en-qualified bit as even parity over the word.
  - The word is offered to the output register on the parity bit, so latency is 1 clk after the parity en.
  - Adds output parity_err (1 bit). It is registered alongside out_data and is valid with out_valid: 1 if the XOR of the word and the parity bit is 1.
  - A sync during PARITY aborts as in SHIFT.
- Undefined:
  - No PARITY state and no parity_err port.
  - Completion is on data bit WIDTH-1.

Test Plan:
- WIDTH=8, out_ready=1; en every cycle, sync with the first bit; bits of 0xA5 LSB first -> out_valid=1 exactly one cycle after the 8th en, out_data=8'hA5; overflow=0.
- 0x3C sent with en toggling every other cycle -> bits are captured only on en=1 cycles; out_data=8'h3C; bit_cnt increments only on en cycles.
- out_ready=0; send 0x11 then 0x22 -> out_data stays 8'h11 and overflow=1. Then ovf_clr=1 -> overflow=0. Then out_ready=1 -> one transfer, out_valid=0.
- out_valid=1 holding 0x11 with out_ready=1 on the completion cycle of 0x22 -> next cycle out_data=8'h22, out_valid=1, overflow=0.
- 4 bits of a word, then en=1 & sync=1 -> abort_pulse high for one cycle, bit_cnt=1; the following full word 0xF0 is emitted as 8'hF0.
- Assert clr after 5 bits with out_valid=1 -> all outputs 0 immediately, before the next clk edge; subsequent 0x5A is received correctly. With BIT_DESER_PARITY_EN: 0x5A plus parity bit 1 -> parity_err=1.

Source files
------------

// File: rtl/bit_deser_capture.sv
// Serial-to-parallel capture: assembles WIDTH-bit words LSB first from an en-qualified bit stream into a valid/ready holding register.
// Optional even-parity trailer bit when BIT_DESER_PARITY_EN is defined (adds parity_err).
module bit_deser_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             d,
  input  logic             en,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic             abort_pulse,
  output logic [CNT_W-1:0] bit_cnt
`ifdef BIT_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;
  logic             abort;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             word_perr;
  logic             load;
  logic             drop;

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (en && sync) state_nxt = SHIFT;
      SHIFT: begin
        if (en && !sync && last_bit) begin
`ifdef BIT_DESER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
`endif
        end
      end
      PARITY: begin
        if (en) state_nxt = sync ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath controls; a sync outside IDLE always restarts the word, even on the completing bit.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    abort     = 1'b0;
    complete  = 1'b0;
    word      = shreg;
    word_perr = 1'b0;
    if (en && sync) begin
      abort     = (state != IDLE);
      shreg_nxt = {{(WIDTH-1){1'b0}}, d};
      cnt_nxt   = CNT_W'(1);
    end else if (en && state == SHIFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == int'(bit_cnt)) shreg_nxt[i] = d;
      end
`ifdef BIT_DESER_PARITY_EN
      // bit_cnt saturates at WIDTH-1 while waiting for the parity bit
      cnt_nxt = last_bit ? bit_cnt : bit_cnt + CNT_W'(1);
`else
      complete = last_bit;
      word     = {d, shreg[WIDTH-2:0]};
      cnt_nxt  = last_bit ? '0 : bit_cnt + CNT_W'(1);
`endif
    end else if (en && state == PARITY) begin
      complete  = 1'b1;
      word      = shreg;
      word_perr = ^shreg ^ d;
      cnt_nxt   = '0;
    end
  end

  assign load = complete && (!out_valid || out_ready);
  assign drop = complete && out_valid && !out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      overflow    <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      shreg       <= shreg_nxt;
      bit_cnt     <= cnt_nxt;
      abort_pulse <= abort;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef BIT_DESER_PARITY_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       parity_err <= 1'b0;
    else if (load) parity_err <= word_perr;
  end
`else
  logic unused_perr;
  assign unused_perr = word_perr;
`endif

endmodule

// File: tb/tb_bit_deser_capture.sv
// Directed-vector bench for bit_deser_capture (WIDTH=8); inputs change 1ns after posedge, outputs sampled there.
module tb_bit_deser_capture;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          clr, d, en, sync, out_ready, ovf_clr;
  logic          out_valid, overflow, abort_pulse;
  logic [W-1:0]  out_data;
  logic [CW-1:0] bit_cnt;
`ifdef BIT_DESER_PARITY_EN
  logic          parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit_deser_capture #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .d(d), .en(en), .sync(sync),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_data(out_data), .overflow(overflow),
    .abort_pulse(abort_pulse), .bit_cnt(bit_cnt)
`ifdef BIT_DESER_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_bit(input logic b, input logic s);
    d = b; sync = s; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; sync = 1'b0; d = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends bits first..last of w (sync on bit 0), gap idle cycles between bits; parity trailer after bit 7.
  task automatic send_word(input logic [7:0] w, input int first, input int last, input int gap, input logic par);
    for (int i = first; i <= last; i++) begin
      tick_bit(w[i], (i == 0));
      if (i < last) idle(gap);
    end
`ifdef BIT_DESER_PARITY_EN
    if (last == 7) tick_bit(par, 1'b0);
`endif
  endtask

  initial begin
    clr = 1'b1; d = 0; en = 0; sync = 0; out_ready = 1'b1; ovf_clr = 0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_abort", abort_pulse, 0);
    check("rst_cnt", bit_cnt, 0);
    @(posedge clk); #1; clr = 1'b0;

    // 0xA5, en every cycle
    send_word(8'hA5, 0, 6, 0, 1'b0);
    check("a5_valid_early", out_valid, 0);
    check("a5_cnt7", bit_cnt, 7);
    send_word(8'hA5, 7, 7, 0, ^8'hA5);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    check("a5_ovf", overflow, 0);
    check("a5_cnt0", bit_cnt, 0);
`ifdef BIT_DESER_PARITY_EN
    check("a5_perr", parity_err, 0);
`endif
    idle(1);
    check("a5_drain", out_valid, 0);

    // 0x3C with en every other cycle
    send_word(8'h3C, 0, 2, 1, 1'b0);
    idle(1);
    check("3c_cnt_hold", bit_cnt, 3);
    send_word(8'h3C, 3, 7, 1, ^8'h3C);
    check("3c_valid", out_valid, 1);
    check("3c_data", out_data, 8'h3C);
    idle(1);

    // overflow with out_ready low
    out_ready = 1'b0;
    send_word(8'h11, 0, 7, 0, ^8'h11);
    check("ovf_first_valid", out_valid, 1);
    send_word(8'h22, 0, 7, 0, ^8'h22);
    check("ovf_data_kept", out_data, 8'h11);
    check("ovf_set", overflow, 1);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_still_valid", out_valid, 1);
    out_ready = 1'b1; idle(1);
    check("ovf_drained", out_valid, 0);
    check("ovf_data_hold", out_data, 8'h11);

    // simultaneous drain and load
    out_ready = 1'b0;
    send_word(8'h11, 0, 7, 0, ^8'h11);
    send_word(8'h22, 0, 6, 0, 1'b0);
    check("sim_hold_data", out_data, 8'h11);
    out_ready = 1'b1;
    send_word(8'h22, 7, 7, 0, ^8'h22);
    check("sim_data", out_data, 8'h22);
    check("sim_valid", out_valid, 1);
    check("sim_ovf", overflow, 0);
    idle(1);

    // abort after 4 bits, then 0xF0
    send_word(8'h0D, 0, 3, 0, 1'b0);
    tick_bit(1'b0, 1'b1);
    check("abort_pulse", abort_pulse, 1);
    check("abort_cnt", bit_cnt, 1);
    send_word(8'hF0, 1, 1, 0, 1'b0);
    check("abort_one_cycle", abort_pulse, 0);
    check("abort_cnt2", bit_cnt, 2);
    send_word(8'hF0, 2, 7, 0, ^8'hF0);
    check("f0_data", out_data, 8'hF0);
    check("f0_valid", out_valid, 1);
    idle(1);

    // sync on the completing bit aborts without emitting
    send_word(8'hFF, 0, 6, 0, 1'b0);
    tick_bit(1'b1, 1'b1);
    check("lastsync_abort", abort_pulse, 1);
    check("lastsync_novalid", out_valid, 0);
    check("lastsync_cnt", bit_cnt, 1);
    out_ready = 1'b0;
    send_word(8'h81, 1, 7, 0, ^8'h81);
    check("w81_data", out_data, 8'h81);

    // async clear mid-word with a pending output
    send_word(8'h33, 0, 4, 0, 1'b0);
    check("pre_clr_cnt", bit_cnt, 5);
    check("pre_clr_valid", out_valid, 1);
    #2 clr = 1'b1;
    #1;
    check("clr_valid", out_valid, 0);
    check("clr_data", out_data, 0);
    check("clr_ovf", overflow, 0);
    check("clr_abort", abort_pulse, 0);
    check("clr_cnt", bit_cnt, 0);
    @(posedge clk); #1; clr = 1'b0; out_ready = 1'b1;
`ifdef BIT_DESER_PARITY_EN
    send_word(8'h5A, 0, 7, 0, 1'b1);
    check("5a_perr", parity_err, 1);
`else
    send_word(8'h5A, 0, 7, 0, 1'b0);
`endif
    check("5a_data", out_data, 8'h5A);
    check("5a_valid", out_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
